// File: rtl/mem_bus_master_pkg.sv
// Shared definitions for the memory bus initiator: state encodings and
// default widths of the 32x8 memory bus, also used by the control unit.
package mem_bus_master_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_bus_master_if.sv
// Request/response handshake between the control unit and the memory bus
// initiator. The master modport is the control unit (issues requests); the
// slave modport is the initiator serving them.
interface mem_bus_master_if
  import mem_bus_master_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;

  modport master (
    output req_valid, req_we, req_addr, req_len, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_last
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_len, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_last
  );

endinterface

// File: rtl/mem_beat_counter.sv
// Down counter with load and zero flag. Holds the number of read beats still
// to be issued; the same count also tells when the final capture happens.
module mem_beat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load takes priority; decrement never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_bus_master.sv
// Initiator for the shared bidirectional memory bus. Serves load/store/fetch
// requests: single-beat writes with an ack, and reads of 1..4 beats issued one
// address per clock with wrap-around, captured one clock behind the address.
module mem_bus_master
  import mem_bus_master_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_master_if.slave   bus,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data
);

  state_t            state, state_d;
  logic              mem_en_d, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              data_oe, data_oe_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_last_q, rsp_last_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              accept;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [LEN_W:0]    cnt_load_val;

  // Only IDLE accepts; reset masks ready so nothing is taken while rst is high.
  assign bus.req_ready = (state == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;

  // Driver enable is a register set only on WRITE entry, so the bus is never
  // driven by this block while mem_rw is low.
  assign mem_data = data_oe ? wdata_q : {DATA_W{1'bz}};

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_last  = rsp_last_q;

  assign cnt_load_val = {1'b0, bus.req_len};

  // Remaining-beat counter: zero in READ means this edge captures the last beat.
  mem_beat_counter #(
    .W (LEN_W + 1)
  ) u_beat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next-state and next-output logic for the bus sequencer.
  always_comb begin
    state_d     = state;
    mem_en_d    = mem_en;
    mem_rw_d    = mem_rw;
    mem_addr_d  = mem_addr;
    data_oe_d   = 1'b0;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_last_d  = 1'b0;
    rsp_data_d  = rsp_data_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    case (state)
      IDLE: begin
        mem_en_d = 1'b0;
        if (accept) begin
          mem_en_d   = 1'b1;
          mem_addr_d = bus.req_addr;
          if (bus.req_we) begin
            state_d   = WRITE;
            mem_rw_d  = 1'b1;
            data_oe_d = 1'b1;
            wdata_d   = bus.req_wdata;
          end else begin
            state_d  = READ;
            mem_rw_d = 1'b0;
            cnt_load = 1'b1;
          end
        end
      end
      READ: begin
        // Every edge in READ captures the beat addressed in the prior cycle.
        rsp_valid_d = 1'b1;
        rsp_data_d  = mem_data;
        if (cnt_zero) begin
          rsp_last_d = 1'b1;
          mem_en_d   = 1'b0;
          state_d    = IDLE;
        end else begin
          mem_addr_d = ADDR_W'(mem_addr + 1'b1);
          cnt_dec    = 1'b1;
        end
      end
      WRITE: begin
        // Memory latched the data on the negedge; release the bus and ack.
        rsp_valid_d = 1'b1;
        rsp_last_d  = 1'b1;
        rsp_data_d  = '0;
        mem_en_d    = 1'b0;
        mem_rw_d    = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        state_d  = IDLE;
        mem_en_d = 1'b0;
        mem_rw_d = 1'b0;
      end
    endcase
  end

  // State and registered bus/response outputs; reset abandons any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_en      <= 1'b0;
      mem_rw      <= 1'b0;
      mem_addr    <= '0;
      data_oe     <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state       <= state_d;
      mem_en      <= mem_en_d;
      mem_rw      <= mem_rw_d;
      mem_addr    <= mem_addr_d;
      data_oe     <= data_oe_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a 32x8 memory model on the bus.
module tb_mem_bus_master;

  logic       clk;
  logic       rst;
  logic       mem_en, mem_rw;
  logic [4:0] mem_addr;
  wire  [7:0] mem_data;

  logic [7:0] mem [32];
  logic       pl_en;
  logic [4:0] pl_addr;
  logic [7:0] pl_data;

  int checks;
  int errors;

  mem_bus_master_if bus ();

  mem_bus_master dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .mem_en   (mem_en),
    .mem_rw   (mem_rw),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  // Memory drives read data combinationally for the current address.
  assign mem_data = (mem_en && !mem_rw) ? mem[mem_addr] : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory latches writes on the negedge; the bench can also preload here.
  always @(negedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_en && mem_rw) mem[mem_addr] <= mem_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [4:0] a, input logic [7:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(negedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic drive_req(input logic we, input logic [4:0] a,
                           input logic [1:0] len, input logic [7:0] d);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a;
    bus.req_len = len; bus.req_wdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) preload(5'(i + 20), 8'h00);
    step(); step();
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_last !== 1'b0 || bus.rsp_data !== 8'h00) begin
      errors++; $display("FAIL reset_rsp got v=%b l=%b d=%h want 0 0 00", bus.rsp_valid, bus.rsp_last, bus.rsp_data); end
    checks++; if (mem_en !== 1'b0 || mem_rw !== 1'b0 || mem_addr !== 5'd0) begin
      errors++; $display("FAIL reset_mem got en=%b rw=%b a=%0d want 0 0 0", mem_en, mem_rw, mem_addr); end
    checks++; if (dut.data_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", dut.data_oe); end
    rst = 1'b0;
    step();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b want 1", bus.req_ready); end
  endtask

  task automatic test_write_read();
    drive_req(1'b1, 5'd5, 2'd0, 8'hA5);
    step();
    bus.req_valid = 1'b0;
    checks++; if (mem_en !== 1'b1 || mem_rw !== 1'b1 || mem_addr !== 5'd5 || mem_data !== 8'hA5) begin
      errors++; $display("FAIL write_cycle got en=%b rw=%b a=%0d d=%h want 1 1 5 a5", mem_en, mem_rw, mem_addr, mem_data); end
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL write_busy got v=%b rdy=%b want 0 0", bus.rsp_valid, bus.req_ready); end
    step();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_last !== 1'b1 || bus.rsp_data !== 8'h00 || mem_en !== 1'b0 || dut.data_oe !== 1'b0) begin
      errors++; $display("FAIL write_ack got v=%b l=%b d=%h en=%b oe=%b want 1 1 00 0 0", bus.rsp_valid, bus.rsp_last, bus.rsp_data, mem_en, dut.data_oe); end
    checks++; if (mem[5] !== 8'hA5) begin errors++; $display("FAIL write_mem got %h want a5", mem[5]); end
    drive_req(1'b0, 5'd5, 2'd0, 8'h00);
    step();
    bus.req_valid = 1'b0;
    checks++; if (mem_en !== 1'b1 || mem_rw !== 1'b0 || mem_addr !== 5'd5 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL read_addr got en=%b rw=%b a=%0d v=%b want 1 0 5 0", mem_en, mem_rw, mem_addr, bus.rsp_valid); end
    step();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'hA5 || bus.rsp_last !== 1'b1 || mem_en !== 1'b0) begin
      errors++; $display("FAIL read_beat got v=%b d=%h l=%b en=%b want 1 a5 1 0", bus.rsp_valid, bus.rsp_data, bus.rsp_last, mem_en); end
    step();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL read_single_pulse got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_burst_wrap();
    logic [4:0] exp_a [4];
    logic [7:0] exp_d [4];
    exp_a[0] = 5'd31; exp_a[1] = 5'd0; exp_a[2] = 5'd1; exp_a[3] = 5'd1;
    exp_d[0] = 8'h1E; exp_d[1] = 8'h1F; exp_d[2] = 8'h00; exp_d[3] = 8'h01;
    preload(5'd30, 8'h1E); preload(5'd31, 8'h1F); preload(5'd0, 8'h00); preload(5'd1, 8'h01);
    step();
    drive_req(1'b0, 5'd30, 2'd3, 8'h00);
    step();
    bus.req_valid = 1'b0;
    checks++; if (mem_addr !== 5'd30 || mem_en !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL burst_first got a=%0d en=%b v=%b want 30 1 0", mem_addr, mem_en, bus.rsp_valid); end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_d[k] || bus.rsp_last !== (k == 3) ||
          mem_addr !== exp_a[k] || mem_en !== (k < 3)) begin
        errors++;
        $display("FAIL burst_beat%0d got v=%b d=%h l=%b a=%0d en=%b want 1 %h %b %0d %b", k,
                 bus.rsp_valid, bus.rsp_data, bus.rsp_last, mem_addr, mem_en,
                 exp_d[k], (k == 3), exp_a[k], (k < 3));
      end
    end
    step();
    checks++; if (bus.rsp_valid !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL burst_end got v=%b en=%b want 0 0", bus.rsp_valid, mem_en); end
  endtask

  task automatic test_write_len();
    preload(5'd6, 8'h66);
    step();
    drive_req(1'b1, 5'd5, 2'd3, 8'h5C);
    step();
    bus.req_valid = 1'b0;
    checks++; if (mem_en !== 1'b1 || mem_rw !== 1'b1 || mem_data !== 8'h5C) begin
      errors++; $display("FAIL wlen_cycle got en=%b rw=%b d=%h want 1 1 5c", mem_en, mem_rw, mem_data); end
    step();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_last !== 1'b1 || mem_en !== 1'b0) begin
      errors++; $display("FAIL wlen_ack got v=%b l=%b en=%b want 1 1 0", bus.rsp_valid, bus.rsp_last, mem_en); end
    step();
    checks++; if (bus.rsp_valid !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL wlen_single got v=%b en=%b want 0 0", bus.rsp_valid, mem_en); end
    checks++; if (mem[5] !== 8'h5C || mem[6] !== 8'h66) begin
      errors++; $display("FAIL wlen_mem got m5=%h m6=%h want 5c 66", mem[5], mem[6]); end
  endtask

  task automatic test_back_to_back();
    drive_req(1'b1, 5'd9, 2'd0, 8'h93);
    step();
    drive_req(1'b0, 5'd9, 2'd0, 8'hFF);
    checks++; if (mem_data !== 8'h93 || bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_write got d=%h rdy=%b want 93 0", mem_data, bus.req_ready); end
    step();
    checks++; if (mem_en !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b1 || mem_addr !== 5'd9) begin
      errors++; $display("FAIL b2b_gap got en=%b v=%b rdy=%b a=%0d want 0 1 1 9", mem_en, bus.rsp_valid, bus.req_ready, mem_addr); end
    step();
    bus.req_valid = 1'b0;
    checks++; if (mem_en !== 1'b1 || mem_rw !== 1'b0 || dut.data_oe !== 1'b0 || mem_addr !== 5'd9) begin
      errors++; $display("FAIL b2b_read got en=%b rw=%b oe=%b a=%0d want 1 0 0 9", mem_en, mem_rw, dut.data_oe, mem_addr); end
    step();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h93 || bus.rsp_last !== 1'b1) begin
      errors++; $display("FAIL b2b_data got v=%b d=%h l=%b want 1 93 1", bus.rsp_valid, bus.rsp_data, bus.rsp_last); end
    step();
  endtask

  task automatic test_reset_mid_burst();
    preload(5'd12, 8'hC0); preload(5'd13, 8'hC1); preload(5'd14, 8'hC2); preload(5'd15, 8'hC3);
    step();
    drive_req(1'b0, 5'd12, 2'd3, 8'h00);
    step();
    bus.req_valid = 1'b0;
    step();
    step();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'hC1) begin
      errors++; $display("FAIL rstmid_beat1 got v=%b d=%h want 1 c1", bus.rsp_valid, bus.rsp_data); end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (bus.rsp_valid !== 1'b0 || mem_en !== 1'b0 || bus.req_ready !== 1'b0) begin
        errors++; $display("FAIL rstmid_quiet%0d got v=%b en=%b rdy=%b want 0 0 0", k, bus.rsp_valid, mem_en, bus.req_ready);
      end
    end
    rst = 1'b0;
    step();
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_release got v=%b rdy=%b want 0 1", bus.rsp_valid, bus.req_ready); end
    drive_req(1'b0, 5'd14, 2'd0, 8'h00);
    step();
    bus.req_valid = 1'b0;
    step();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'hC2 || bus.rsp_last !== 1'b1) begin
      errors++; $display("FAIL rstmid_new got v=%b d=%h l=%b want 1 c2 1", bus.rsp_valid, bus.rsp_data, bus.rsp_last); end
  endtask

  // Runs each scenario in order and prints the summary.
  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_len = '0; bus.req_wdata = '0;
    test_reset();
    test_write_read();
    test_burst_wrap();
    test_write_len();
    test_back_to_back();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
